// File: rtl/skullfet_inverter_tester.sv
// rtl/skullfet_inverter_tester.sv - self-test sequencer for SkullFET inverter cells
// Steps a vector onto the inverter array, waits for settle, checks Y == ~A and keeps statistics.
module skullfet_inverter_tester #(
  parameter int NUM_INV  = 2,
  parameter int CNT_W    = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    cfg_iters,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [NUM_INV-1:0]  inv_a,
  input  logic [NUM_INV-1:0]  inv_y,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    iter_count,
  output logic [NUM_INV-1:0]  first_fail,
  output logic [NUM_INV-1:0]  fail_mask
);

  localparam int WAIT_W = SETTLE_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                start_q;
  logic [NUM_INV-1:0]  y_meta_q, y_sync_q;
  logic [CNT_W-1:0]    iters_q, iters_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [NUM_INV-1:0]  vec_q, vec_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [NUM_INV-1:0]  inv_a_q, inv_a_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                aborted_q, aborted_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CNT_W-1:0]    iter_q, iter_d;
  logic [NUM_INV-1:0]  first_fail_q, first_fail_d;
  logic [NUM_INV-1:0]  fail_mask_q, fail_mask_d;

  logic                start_rise;
  logic [NUM_INV-1:0]  mism;
  logic [CNT_W-1:0]    iter_inc;

  assign start_rise = start & ~start_q;
  assign mism       = y_sync_q ^ ~inv_a_q;
  assign iter_inc   = iter_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    iters_d      = iters_q;
    settle_d     = settle_q;
    vec_d        = vec_q;
    wait_d       = wait_q;
    inv_a_d      = inv_a_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    aborted_d    = aborted_q;
    err_d        = err_q;
    iter_d       = iter_q;
    first_fail_d = first_fail_q;
    fail_mask_d  = fail_mask_q;

    case (state_q)
      IDLE: begin
        if (start_rise && !abort) begin
          iters_d      = cfg_iters;
          settle_d     = cfg_settle;
          err_d        = '0;
          iter_d       = '0;
          first_fail_d = '0;
          fail_mask_d  = '0;
          pass_d       = 1'b0;
          aborted_d    = 1'b0;
          busy_d       = 1'b1;
          vec_d        = '0;
          state_d      = (cfg_iters == '0) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        // The +2 accounts for the two synchroniser stages on inv_y.
        inv_a_d = vec_q;
        wait_d  = {1'b0, settle_q} + WAIT_W'(2);
        state_d = SETTLE;
      end
      SETTLE: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mism != '0) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          fail_mask_d = fail_mask_q | mism;
          if (err_q == '0) first_fail_d = inv_a_q;
        end
        iter_d  = iter_inc;
        vec_d   = vec_q + NUM_INV'(1);
        state_d = (iter_inc == iters_q) ? DONE : DRIVE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0) && !aborted_q && !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides sequencing but lets a coincident SAMPLE update land.
    if (abort && state_q != IDLE && state_q != DONE) begin
      state_d   = DONE;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      y_meta_q     <= '0;
      y_sync_q     <= '0;
      iters_q      <= '0;
      settle_q     <= '0;
      vec_q        <= '0;
      wait_q       <= '0;
      inv_a_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_q        <= '0;
      iter_q       <= '0;
      first_fail_q <= '0;
      fail_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      y_meta_q     <= inv_y;
      y_sync_q     <= y_meta_q;
      iters_q      <= iters_d;
      settle_q     <= settle_d;
      vec_q        <= vec_d;
      wait_q       <= wait_d;
      inv_a_q      <= inv_a_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      aborted_q    <= aborted_d;
      err_q        <= err_d;
      iter_q       <= iter_d;
      first_fail_q <= first_fail_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  assign inv_a      = inv_a_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign iter_count = iter_q;
  assign first_fail = first_fail_q;
  assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_skullfet_inverter_tester.sv
// tb/tb_skullfet_inverter_tester.sv - directed self-checking bench for skullfet_inverter_tester
// Counters are 8 bits wide here so the saturation run stays short.
module tb_skullfet_inverter_tester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_iters = 8'd0;
  logic [7:0] cfg_settle = 8'd0;
  logic [1:0] inv_a, inv_y;
  logic       busy, done, pass;
  logic [7:0] err_count, iter_count;
  logic [1:0] first_fail, fail_mask;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  bit hold_start = 1'b0;
  logic [1:0] hist [0:2047];
  logic       busy_hist [0:2047];
  logic [1:0] d1, d2, d3;

  always #5 clk = ~clk;

  skullfet_inverter_tester #(.NUM_INV(2), .CNT_W(8), .SETTLE_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .cfg_iters(cfg_iters), .cfg_settle(cfg_settle), .inv_a(inv_a), .inv_y(inv_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .iter_count(iter_count), .first_fail(first_fail), .fail_mask(fail_mask)
  );

  // Slow-cell model: Y follows A three clock edges late.
  always @(posedge clk) begin
    d1 <= inv_a;
    d2 <= d1;
    d3 <= d2;
  end

  always_comb begin
    case (mode)
      1:       inv_y = {1'b0, ~inv_a[0]};
      2:       inv_y = {1'b1, ~inv_a[0]};
      3:       inv_y = ~d3;
      4:       inv_y = inv_a;
      default: inv_y = ~inv_a;
    endcase
  end

  task automatic run(input logic [7:0] iters, input logic [7:0] settle, input int abort_at,
                     output int cyc, output bit got);
    @(negedge clk);
    cfg_iters = iters;
    cfg_settle = settle;
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold_start) begin
        start = 1'b0;
        cfg_iters = 8'd1;
        cfg_settle = 8'h55;
      end
      hist[cyc] = inv_a;
      busy_hist[cyc] = busy;
      abort = (cyc == abort_at);
      if (done) got = 1'b1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({inv_a, busy, done, pass, err_count, iter_count, first_fail, fail_mask} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {inv_a, busy, done, pass, err_count, iter_count, first_fail, fail_mask});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ideal();
    int cyc; bit got;
    mode = 0;
    run(8'd4, 8'd0, -1, cyc, got);
    checks++;
    if (!got || cyc != 18) begin failures++; $display("FAIL ideal_latency got=%0d/%0d exp=1/18", got, cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hist[2 + 4 * i] !== 2'(i)) begin failures++; $display("FAIL ideal_vec%0d got=%0d exp=%0d", i, hist[2 + 4 * i], i); end
    end
    checks++;
    if (busy_hist[17] !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ideal_busy got=%b%b exp=10", busy_hist[17], busy); end
    checks++;
    if ({pass, err_count, iter_count} !== {1'b1, 8'd0, 8'd4}) begin
      failures++; $display("FAIL ideal_stats got=%b/%0d/%0d exp=1/0/4", pass, err_count, iter_count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL ideal_done_once got=%b exp=0", done); end
  endtask

  task automatic test_stuck();
    int cyc; bit got;
    mode = 1;
    run(8'd4, 8'd0, -1, cyc, got);
    checks++;
    if (!got || {pass, err_count, fail_mask, first_fail} !== {1'b0, 8'd2, 2'b10, 2'b00}) begin
      failures++;
      $display("FAIL stuck0 got=%b/%0d/%b/%b exp=0/2/10/00", pass, err_count, fail_mask, first_fail);
    end
    mode = 2;
    run(8'd4, 8'd0, -1, cyc, got);
    checks++;
    if (!got || {pass, err_count, fail_mask, first_fail} !== {1'b0, 8'd2, 2'b10, 2'b10}) begin
      failures++;
      $display("FAIL stuck1 got=%b/%0d/%b/%b exp=0/2/10/10", pass, err_count, fail_mask, first_fail);
    end
    mode = 0;
  endtask

  task automatic test_zero_iters();
    int cyc; bit got;
    run(8'd0, 8'd0, -1, cyc, got);
    checks++;
    if (!got || cyc != 2) begin failures++; $display("FAIL zero_latency got=%0d/%0d exp=1/2", got, cyc); end
    checks++;
    if (busy_hist[1] !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b%b exp=10", busy_hist[1], busy); end
    checks++;
    if ({pass, iter_count, inv_a} !== {1'b1, 8'd0, 2'd3}) begin
      failures++; $display("FAIL zero_stats got=%b/%0d/%0d exp=1/0/3", pass, iter_count, inv_a);
    end
  endtask

  task automatic test_abort();
    int cyc; bit got; int n;
    run(8'd6, 8'd0, 10, cyc, got);
    checks++;
    if (!got || cyc != 12) begin failures++; $display("FAIL abort_latency got=%0d/%0d exp=1/12", got, cyc); end
    checks++;
    if ({iter_count, pass, busy, inv_a} !== {8'd2, 1'b0, 1'b0, 2'd2}) begin
      failures++; $display("FAIL abort_stats got=%0d/%b/%b/%0d exp=2/0/0/2", iter_count, pass, busy, inv_a);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(busy) + int'(done);
    end
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (n != 0) begin failures++; $display("FAIL abort_start_idle got=%0d exp=0", n); end
  endtask

  task automatic test_settle_delay();
    int cyc; bit got;
    mode = 3;
    run(8'd4, 8'd0, -1, cyc, got);
    checks++;
    if (!got || pass !== 1'b0 || err_count == 8'd0) begin
      failures++; $display("FAIL slow_settle0 got=%b/%0d exp=0/nonzero", pass, err_count);
    end
    run(8'd4, 8'd3, -1, cyc, got);
    checks++;
    if (!got || {pass, err_count, iter_count} !== {1'b1, 8'd0, 8'd4}) begin
      failures++; $display("FAIL slow_settle3 got=%b/%0d/%0d exp=1/0/4", pass, err_count, iter_count);
    end
    mode = 0;
  endtask

  task automatic test_reset_midrun();
    int n;
    @(negedge clk);
    cfg_iters = 8'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({inv_a, busy, done, pass, err_count, iter_count, first_fail, fail_mask} !== 25'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%h exp=0",
               {inv_a, busy, done, pass, err_count, iter_count, first_fail, fail_mask});
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(busy) + int'(done);
    end
    checks++;
    if (n != 0) begin failures++; $display("FAIL midrun_no_done got=%0d exp=0", n); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit got; int n;
    hold_start = 1'b1;
    run(8'd1, 8'd0, -1, cyc, got);
    checks++;
    if (!got || {pass, iter_count} !== {1'b1, 8'd1}) begin
      failures++; $display("FAIL held_run got=%b/%0d exp=1/1", pass, iter_count);
    end
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(busy);
    end
    checks++;
    if (n != 0) begin failures++; $display("FAIL held_retrigger got=%0d exp=0", n); end
    hold_start = 1'b0;
    start = 1'b0;
    mode = 4;
    run(8'd255, 8'd0, -1, cyc, got);
    checks++;
    if (!got || {err_count, iter_count, fail_mask, first_fail, pass} !== {8'hFF, 8'hFF, 2'b11, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL all_fail got=%h/%h/%b/%b/%b exp=ff/ff/11/00/0",
               err_count, iter_count, fail_mask, first_fail, pass);
    end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_zero_iters();
    test_stuck();
    test_abort();
    test_settle_delay();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
